// File: rtl/mux_unstriping.sv
// Two-lane to one-stream merger: per-lane FIFOs re-interleaved in strict 0,1,0,1 order.
// Optional build macro MUX_UNSTRIPE_CNT_EN adds a 16-bit count of emitted words (out_count).

module mux_unstriping_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_req,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head_c,
  output logic              empty_c,
  output logic              overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full_c;
  logic              wr_en_c;
  logic              drop_c;

  // A full FIFO still accepts a push when it pops on the same edge
  always_comb begin
    full_c  = (count == FULL_CNT);
    empty_c = (count == '0);
    wr_en_c = wr_req && (!full_c || rd_en);
    drop_c  = wr_req && full_c && !rd_en;
    head_c  = mem[rd_ptr];
  end

  always_ff @(posedge clk_2f) begin
    if (wr_en_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en)   rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count + CNT_W'(wr_en_c) - CNT_W'(rd_en);
      overflow <= overflow | drop_c;
    end
  end

endmodule

module mux_unstriping #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_sel,
  output logic              overflow0,
  output logic              overflow1
`ifdef MUX_UNSTRIPE_CNT_EN
  ,
  output logic [15:0]       out_count
`endif
);

  typedef enum logic {L0 = 1'b0, L1 = 1'b1} sel_t;

  sel_t              state;
  sel_t              state_nxt;
  logic              pop0_c;
  logic              pop1_c;
  logic              empty0_c;
  logic              empty1_c;
  logic [DATA_W-1:0] head0_c;
  logic [DATA_W-1:0] head1_c;

  mux_unstriping_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk_2f   (clk_2f),
    .reset_L  (reset_L),
    .wr_data  (data_in0),
    .wr_req   (valid_in0),
    .rd_en    (pop0_c),
    .head_c   (head0_c),
    .empty_c  (empty0_c),
    .overflow (overflow0)
  );

  mux_unstriping_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk_2f   (clk_2f),
    .reset_L  (reset_L),
    .wr_data  (data_in1),
    .wr_req   (valid_in1),
    .rd_en    (pop1_c),
    .head_c   (head1_c),
    .empty_c  (empty1_c),
    .overflow (overflow1)
  );

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) state <= L0;
    else          state <= state_nxt;
  end

  // Advance to the other lane only after a word was taken from the current one
  always_comb begin
    state_nxt = state;
    if (pop0_c || pop1_c) state_nxt = (state == L0) ? L1 : L0;
  end

  // Only the selected lane may pop; the other lane waits its turn
  always_comb begin
    pop0_c = 1'b0;
    pop1_c = 1'b0;
    case (state)
      L0:      pop0_c = !empty0_c;
      L1:      pop1_c = !empty1_c;
      default: ;
    endcase
  end

  assign lane_sel = state;

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop0_c || pop1_c;
      if (pop0_c)      data_out <= head0_c;
      else if (pop1_c) data_out <= head1_c;
    end
  end

`ifdef MUX_UNSTRIPE_CNT_EN
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L)              out_count <= 16'd0;
    else if (pop0_c || pop1_c) out_count <= out_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_unstriping.sv
// Scoreboard bench for mux_unstriping: directed lane patterns, expected words queued up front.
// Define MUX_UNSTRIPE_CNT_EN to also exercise out_count.

module tb_mux_unstriping;

  logic        clk_2f = 1'b0;
  logic        reset_L;
  logic [31:0] data_in0;
  logic        valid_in0;
  logic [31:0] data_in1;
  logic        valid_in1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        lane_sel;
  logic        overflow0;
  logic        overflow1;
`ifdef MUX_UNSTRIPE_CNT_EN
  logic [15:0] out_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  mux_unstriping #(.DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk_2f    (clk_2f),
    .reset_L   (reset_L),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_sel  (lane_sel),
    .overflow0 (overflow0),
    .overflow1 (overflow1)
`ifdef MUX_UNSTRIPE_CNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid output word must match the head of the expected queue
  always @(negedge clk_2f) begin
    if (reset_L === 1'b1 && valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected no output at %0t", data_out, $time);
      end else begin
        chk("stream", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic step(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    valid_in0 = v0;
    data_in0  = d0;
    valid_in1 = v1;
    data_in1  = d1;
    tick();
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    data_in0  = '0;
    data_in1  = '0;
    do_reset();
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_lane_sel", 32'(lane_sel), 32'h0);
    chk("rst_overflow0", 32'(overflow0), 32'h0);
    chk("rst_overflow1", 32'(overflow1), 32'h0);

    // Test 1: both lanes in lock-step
    exp_q.push_back(32'hA0); exp_q.push_back(32'hB0);
    exp_q.push_back(32'hA1); exp_q.push_back(32'hB1);
    step(1'b1, 32'hA0, 1'b1, 32'hB0);
    step(1'b1, 32'hA1, 1'b1, 32'hB1);
    chk("t1_first_valid", 32'(valid_out), 32'h1);
    chk("t1_first_data", data_out, 32'hA0);
    tick();
    tick();
`ifdef MUX_UNSTRIPE_CNT_EN
    chk("t6_count3", 32'(out_count), 32'd3);
`endif
    tick();
    tick();
    chk("t1_idle_valid", 32'(valid_out), 32'h0);
    chk("t1_lane_sel", 32'(lane_sel), 32'h0);

    // Test 2: lane 1 arrives late
    exp_q.push_back(32'h10); exp_q.push_back(32'h20);
    exp_q.push_back(32'h11); exp_q.push_back(32'h21);
    step(1'b1, 32'h10, 1'b0, 32'h0);
    step(1'b1, 32'h11, 1'b0, 32'h0);
    chk("t2_first_data", data_out, 32'h10);
    tick();
    chk("t2_wait_valid", 32'(valid_out), 32'h0);
    chk("t2_wait_sel", 32'(lane_sel), 32'h1);
    tick();
    step(1'b0, 32'h0, 1'b1, 32'h20);
    step(1'b0, 32'h0, 1'b1, 32'h21);
    chk("t2_lane1_data", data_out, 32'h20);
    tick();
    tick();
    tick();
    chk("t2_overflow0", 32'(overflow0), 32'h0);
    chk("t2_overflow1", 32'(overflow1), 32'h0);

    // Test 3: lane 0 overflows while lane 1 is idle; 0x15 is dropped
    exp_q.push_back(32'h10); exp_q.push_back(32'h60);
    exp_q.push_back(32'h11); exp_q.push_back(32'h61);
    exp_q.push_back(32'h12); exp_q.push_back(32'h62);
    exp_q.push_back(32'h13); exp_q.push_back(32'h63);
    exp_q.push_back(32'h14);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 32'h0);
    chk("t3_no_ovf_at_fill", 32'(overflow0), 32'h0);
    step(1'b1, 32'h15, 1'b0, 32'h0);
    chk("t3_overflow0_set", 32'(overflow0), 32'h1);
    chk("t3_stalled", 32'(valid_out), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 32'h60 + 32'(i));
    repeat (7) tick();
    chk("t3_overflow0_sticky", 32'(overflow0), 32'h1);
    chk("t3_overflow1", 32'(overflow1), 32'h0);
    chk("t3_drained", 32'(valid_out), 32'h0);

    do_reset();
    chk("t3_ovf_cleared", 32'(overflow0), 32'h0);

    // Test 4: lane 0 full, selected, and pushed on the same edge it pops
    exp_q.push_back(32'h40); exp_q.push_back(32'h50);
    exp_q.push_back(32'h41); exp_q.push_back(32'h51);
    exp_q.push_back(32'h42); exp_q.push_back(32'h52);
    exp_q.push_back(32'h43); exp_q.push_back(32'h53);
    exp_q.push_back(32'h44); exp_q.push_back(32'h54);
    exp_q.push_back(32'h45); exp_q.push_back(32'h55);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h40 + 32'(i), 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h50);
    step(1'b0, 32'h0, 1'b1, 32'h51);
    chk("t4_sel_lane0", 32'(lane_sel), 32'h0);
    step(1'b1, 32'h45, 1'b0, 32'h0);
    chk("t4_no_drop", 32'(overflow0), 32'h0);
    chk("t4_pop_data", data_out, 32'h41);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 32'h52 + 32'(i));
    repeat (6) tick();
    chk("t4_overflow0_end", 32'(overflow0), 32'h0);
    chk("t4_drained", 32'(valid_out), 32'h0);

    // Test 5: asynchronous reset with both FIFOs half full
    exp_q.push_back(32'h70); exp_q.push_back(32'h80);
    step(1'b1, 32'h70, 1'b1, 32'h80);
    step(1'b1, 32'h71, 1'b1, 32'h81);
    step(1'b1, 32'h72, 1'b1, 32'h82);
    @(negedge clk_2f);
    #1 reset_L = 1'b0;
    #1;
    chk("t5_async_data", data_out, 32'h0);
    chk("t5_async_valid", 32'(valid_out), 32'h0);
    chk("t5_async_sel", 32'(lane_sel), 32'h0);
    #1 reset_L = 1'b1;
    exp_q.push_back(32'h55); exp_q.push_back(32'h66);
    step(1'b1, 32'h55, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h66);
    chk("t5_first_after_rst", data_out, 32'h55);
    tick();
    chk("t5_second_after_rst", data_out, 32'h66);
    tick();
    chk("t5_idle", 32'(valid_out), 32'h0);

`ifdef MUX_UNSTRIPE_CNT_EN
    // Test 6: counter wrap after 65536 outputs, lanes alternating one push per edge
    do_reset();
    for (int j = 0; j < 65536; j++) begin
      exp_q.push_back(32'(j));
      if (j % 2 == 0) step(1'b1, 32'(j), 1'b0, 32'h0);
      else            step(1'b0, 32'h0, 1'b1, 32'(j));
    end
    chk("t6_count_ffff", 32'(out_count), 32'h0000FFFF);
    tick();
    chk("t6_count_wrap", 32'(out_count), 32'h0);
`endif

    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_words: got %0d words never output, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
